clkdiv_ctrl: RTL and testbench

Programmable clock-divider controller that sequences a divide-by-N counter and drives a divided clock output. Configuration requests arrive over a valid/ready handshake and are applied only on output-period boundaries; start/stop is glitch-free. It sits between the system configuration logic and any logic clocked or enabled from the divided clock. It generalises the fixed divide-by-8 divider into a run-time schedulable resource.

---
 rtl/clkdiv_pkg.sv | 14 +
 rtl/clkdiv_core.sv | 43 ++++
 rtl/clkdiv_ctrl.sv | 98 +++++++++
 tb/tb_clkdiv_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider: FSM encodings,
// the minimum legal ratio and the ratio loaded at reset.
package clkdiv_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;

  localparam int MIN_DIV        = 2;
  localparam int CLKDIV_DEF_DIV = 8;

endpackage

// File: rtl/clkdiv_core.sv
// Divide-by-N period counter. The high phase is ceil(N/2) cycles, and the
// divided clock and tick are registered. The last output flags the final cycle of a period.
module clkdiv_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div,
  output logic             clk_out,
  output logic             tick,
  output logic             last
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;

  // One extra bit keeps ceil(N/2) exact at N = 2^CNT_W-1.
  function automatic logic [CNT_W:0] hi_len(input logic [CNT_W-1:0] n);
    return ({1'b0, n} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
  endfunction

  assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign last    = (cnt == (div - {{(CNT_W-1){1'b0}}, 1'b1}));

  always_ff @(posedge clk) begin
    if (rst_ || !en) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (load) begin
      cnt     <= '0;
      clk_out <= 1'b1;
      tick    <= 1'b1;
    end else begin
      cnt     <= cnt_inc[CNT_W-1:0];
      clk_out <= (cnt_inc < hi_len(div));
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Clock-divider controller. It runs the IDLE/RUN/DRAIN sequencing and the ratio
// handshake. A ratio accepted while running is held and applied on a period boundary.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = CLKDIV_DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             run,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div
);

  state_t           state;
  state_t           state_nxt;
  logic             pending;
  logic             pend_used;
  logic [CNT_W-1:0] pend_div;
  logic             last;
  logic             idle;
  logic             acc;
  logic             legal;
  logic             boundary;
  logic             apply_pend;
  logic             core_en;
  logic             core_load;

  assign cfg_ready = !pending;
  assign busy      = (state != IDLE);

  always_comb begin
    idle       = (state == IDLE);
    acc        = cfg_valid && cfg_ready;
    legal      = (cfg_div >= CNT_W'(MIN_DIV));
    boundary   = idle || last;
    apply_pend = pending && !pend_used && boundary;
    // A period ending while run is low is the end of the drain: stop the core.
    core_en    = idle ? run : !(last && !run);
    core_load  = idle ? run : last;
    state_nxt  = IDLE;
    case (state)
      IDLE:       state_nxt = run ? RUN : IDLE;
      RUN, DRAIN: state_nxt = (last && !run) ? IDLE : (run ? RUN : DRAIN);
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state     <= IDLE;
      cur_div   <= CNT_W'(DEF_DIV);
      pending   <= 1'b0;
      pend_used <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= acc && !legal;
      // Pending stays set one cycle past the load so cfg_ready rises a cycle later.
      if (pend_used) begin
        pending   <= 1'b0;
        pend_used <= 1'b0;
      end else if (apply_pend) begin
        cur_div   <= pend_div;
        pend_used <= 1'b1;
      end
      if (acc && legal) begin
        if (idle) cur_div <= cfg_div;
        else      pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc && legal && !idle) pend_div <= cfg_div;
  end

  clkdiv_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk     (clk),
    .rst_    (rst_),
    .en      (core_en),
    .load    (core_load),
    .div     (cur_div),
    .clk_out (clk_out),
    .tick    (tick),
    .last    (last)
  );

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: start, ratio changes, illegal ratios,
// drain/restart, reset with a pending ratio, and extreme ratios.
module tb_clkdiv_ctrl;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready;
  logic       cfg_err;
  logic       run = 1'b0;
  logic       clk_out;
  logic       tick;
  logic       busy;
  logic [7:0] cur_div;

  int n_chk  = 0;
  int n_pass = 0;

  clkdiv_ctrl #(.CNT_W(8), .DEF_DIV(8)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .run       (run),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .cur_div   (cur_div)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Check period positions from..to-1 of an N-cycle period, one per cycle.
  task automatic span(input int n, input int from, input int to);
    for (int i = from; i < to; i++) begin
      check($sformatf("clk_out N=%0d i=%0d", n, i), 32'(clk_out), 32'(i < (n + 1) / 2));
      check($sformatf("tick N=%0d i=%0d", n, i), 32'(tick), 32'(i == 0));
      step(1);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " clk_out"}, 32'(clk_out), 0);
    check({tag, " tick"}, 32'(tick), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " cfg_err"}, 32'(cfg_err), 0);
    check({tag, " cfg_ready"}, 32'(cfg_ready), 1);
    check({tag, " cur_div"}, 32'(cur_div), 8);
  endtask

  initial begin
    step(2);
    check_reset("reset");

    // Start at DEF_DIV=8: tick/high from the edge after run is sampled
    rst_ = 1'b0; run = 1'b1;
    step(1);
    check("busy start", 32'(busy), 1);
    span(8, 0, 8);
    span(8, 0, 3);

    // Mid-period change to 3
    cfg_valid = 1'b1; cfg_div = 8'd3;
    check("ready before offer", 32'(cfg_ready), 1);
    step(1);
    cfg_valid = 1'b0;
    check("ready held", 32'(cfg_ready), 0);
    check("cur_div old", 32'(cur_div), 8);
    span(8, 4, 8);
    check("cur_div new", 32'(cur_div), 3);
    check("ready at load", 32'(cfg_ready), 0);
    check("tick new period", 32'(tick), 1);
    step(1);
    check("ready after load", 32'(cfg_ready), 1);
    span(3, 1, 3);
    span(3, 0, 3);

    // Illegal ratios 1 then 0
    cfg_valid = 1'b1; cfg_div = 8'd1;
    step(1);
    cfg_valid = 1'b0;
    check("err div1", 32'(cfg_err), 1);
    check("ready div1", 32'(cfg_ready), 1);
    check("cur_div div1", 32'(cur_div), 3);
    span(3, 1, 2);
    check("err div1 clear", 32'(cfg_err), 0);
    span(3, 2, 3);
    cfg_valid = 1'b1; cfg_div = 8'd0;
    step(1);
    cfg_valid = 1'b0;
    check("err div0", 32'(cfg_err), 1);
    span(3, 1, 2);
    check("err div0 clear", 32'(cfg_err), 0);
    span(3, 2, 3);
    check("cur_div after illegal", 32'(cur_div), 3);
    span(3, 0, 3);

    // Switch to 6, drop run in high phase, reassert during drain
    cfg_valid = 1'b1; cfg_div = 8'd6;
    step(1);
    cfg_valid = 1'b0;
    span(3, 1, 3);
    check("cur_div 6", 32'(cur_div), 6);
    span(6, 0, 2);
    run = 1'b0;
    span(6, 2, 4);
    check("busy drain", 32'(busy), 1);
    run = 1'b1;
    span(6, 4, 6);
    span(6, 0, 2);
    run = 1'b0;
    span(6, 2, 6);
    check("busy idle", 32'(busy), 0);
    check("clk_out idle", 32'(clk_out), 0);
    check("tick idle", 32'(tick), 0);
    step(1);
    check("clk_out idle 2", 32'(clk_out), 0);

    // run and ratio 4 in the same IDLE cycle
    run = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd4;
    step(1);
    cfg_valid = 1'b0;
    check("cur_div idle load", 32'(cur_div), 4);
    check("ready idle load", 32'(cfg_ready), 1);
    span(4, 0, 4);

    // Reset in low phase with pending 5
    cfg_valid = 1'b1; cfg_div = 8'd5;
    step(1);
    cfg_valid = 1'b0;
    check("ready pend5", 32'(cfg_ready), 0);
    span(4, 1, 3);
    check("low phase before rst", 32'(clk_out), 0);
    rst_ = 1'b1;
    step(1);
    check_reset("mid rst");
    rst_ = 1'b0;
    step(1);
    check("cur_div after rst", 32'(cur_div), 8);
    span(8, 0, 8);
    span(8, 0, 8);
    check("pend5 dropped", 32'(cur_div), 8);

    // Extremes: 255 then 2
    cfg_valid = 1'b1; cfg_div = 8'd255;
    span(8, 0, 1);
    cfg_valid = 1'b0;
    span(8, 1, 8);
    check("cur_div 255", 32'(cur_div), 255);
    span(255, 0, 100);
    cfg_valid = 1'b1; cfg_div = 8'd2;
    span(255, 100, 101);
    cfg_valid = 1'b0;
    span(255, 101, 255);
    check("cur_div 2", 32'(cur_div), 2);
    span(2, 0, 2);
    span(2, 0, 2);
    run = 1'b0;
    span(2, 0, 2);
    check("busy final", 32'(busy), 0);
    check("clk_out final", 32'(clk_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
